// File: rtl/operand_selector_pkg.sv
// ---------------------------------------------------------------------------
// operand_selector_pkg
//   Shared matrix-unit definitions: operation encodings, error codes and the
//   operand selector state encoding. Also imported by ctrl_fsm so both
//   blocks agree on what an op_sel value and an err_code value mean.
// ---------------------------------------------------------------------------
package operand_selector_pkg;

  // Matrix operation encodings (op_sel)
  localparam logic [2:0] OP_TRANS  = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SCALAR = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_DET    = 3'b100;

  // err_code values
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_EMPTY   = 2'b01;  // picked slot holds no matrix
  localparam logic [1:0] ERR_DIM     = 2'b10;  // dimensions incompatible
  localparam logic [1:0] ERR_NO_PAIR = 2'b11;  // scan exhausted, or invalid op

  // Operand selector states
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WAIT_A = 4'd1,
    S_WAIT_B = 4'd2,
    S_LOOK_A = 4'd3,
    S_LOOK_B = 4'd4,
    S_CHECK  = 4'd5,
    S_SCAN_A = 4'd6,
    S_SCAN_B = 4'd7,
    S_DONE   = 4'd8,
    S_ERR    = 4'd9
  } sel_state_e;

  // 101..111 are not assigned to any operation.
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_DET);
  endfunction

  // Unary operations only need operand A; B mirrors A.
  function automatic logic op_is_unary(input logic [2:0] op);
    return (op == OP_TRANS) || (op == OP_SCALAR) || (op == OP_DET);
  endfunction

endpackage

// File: rtl/operand_selector_dim_compat.sv
// ---------------------------------------------------------------------------
// dim_compat_check
//   Purely combinational dimension compatibility test for one operation.
//   Ports:
//     op              operation encoding (operand_selector_pkg OP_*)
//     rows_a, cols_a  dimensions of operand A
//     rows_b, cols_b  dimensions of operand B (ignored for unary ops)
//     pass            1 when the operands can be used with op
// ---------------------------------------------------------------------------
module dim_compat_check
  import operand_selector_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] rows_a,
  input  logic [2:0] cols_a,
  input  logic [2:0] rows_b,
  input  logic [2:0] cols_b,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (op)
      OP_TRANS:  pass = 1'b1;
      OP_SCALAR: pass = 1'b1;
      OP_DET:    pass = (rows_a == cols_a);
      OP_ADD:    pass = (rows_a == rows_b) && (cols_a == cols_b);
      OP_MUL:    pass = (cols_a == rows_b);
      default:   pass = 1'b0;  // unassigned encodings never pass
    endcase
  end

endmodule

// File: rtl/operand_selector.sv
// ---------------------------------------------------------------------------
// operand_selector
//   Chooses the storage slot(s) feeding a matrix operation, either from user
//   key presses (manual) or by scanning all 16 slots for the first
//   dimension-compatible pair (auto).
//
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     start_select      one-cycle request; restarts the block from any state
//     manual_mode       sampled with start_select: 1 manual, 0 auto scan
//     op_sel            sampled with start_select: operation encoding
//     key_confirm       one-cycle confirm pulse, sw_id sampled with it
//     sw_id             manually chosen slot ID
//     slot_valid        bit i set when slot i holds a matrix (sampled live)
//     dim_addr          dimension lookup address
//     dim_rows/cols     dimensions of dim_addr, valid one cycle after it
//     select_busy       high in every state except IDLE, DONE, ERR
//     select_done       level, high in DONE
//     select_error      one-cycle pulse on entry to ERR
//     err_code          cause of the error, held until the next start
//     selected_a/b      chosen IDs (B mirrors A for unary ops)
//     state_dbg         current FSM state for observation
//
//   Handshake: start_select and key_confirm are single-cycle strobes with no
//   back-pressure; each is acted on in the cycle it is high. start_select
//   has priority, so a key press in the same cycle is dropped. Results are
//   reported by select_done (level) or select_error (pulse) and stay valid
//   until the next start_select.
// ---------------------------------------------------------------------------
module operand_selector
  import operand_selector_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_select,
  input  logic        manual_mode,
  input  logic [2:0]  op_sel,
  input  logic        key_confirm,
  input  logic [3:0]  sw_id,
  input  logic [15:0] slot_valid,
  output logic [3:0]  dim_addr,
  input  logic [2:0]  dim_rows,
  input  logic [2:0]  dim_cols,
  output logic        select_busy,
  output logic        select_done,
  output logic        select_error,
  output logic [1:0]  err_code,
  output logic [3:0]  selected_a,
  output logic [3:0]  selected_b,
  output logic [3:0]  state_dbg
);

  sel_state_e state;
  logic       phase;     // 0: address cycle, 1: dims valid / capture cycle
  logic [2:0] op_q;
  logic       manual_q;
  logic [2:0] rows_a, cols_a, rows_b, cols_b;

  logic unary;
  logic compat_pass;
  logic adv_a;           // auto scan: move to next A candidate
  logic adv_b;           // auto scan: move to next B candidate

  assign unary     = op_is_unary(op_q);
  assign state_dbg = state;

  dim_compat_check u_compat (
    .op     (op_q),
    .rows_a (rows_a),
    .cols_a (cols_a),
    .rows_b (rows_b),
    .cols_b (cols_b),
    .pass   (compat_pass)
  );

  // Scan stepping is decided here so all the "try the next slot" paths
  // (empty slot, failed check, B wrap) share one update in the FSM.
  always_comb begin
    adv_b = 1'b0;
    adv_a = 1'b0;
    if (state == S_SCAN_B && !phase && !slot_valid[selected_b])
      adv_b = 1'b1;
    if (state == S_CHECK && !manual_q && !compat_pass && !unary)
      adv_b = 1'b1;
    if (state == S_SCAN_A && !phase && !slot_valid[selected_a])
      adv_a = 1'b1;
    if (state == S_CHECK && !manual_q && !compat_pass && unary)
      adv_a = 1'b1;
    // B past slot 15 rolls over into the next A candidate.
    if (adv_b && (selected_b == 4'd15))
      adv_a = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      op_q         <= 3'b000;
      manual_q     <= 1'b0;
      rows_a       <= 3'd0;
      cols_a       <= 3'd0;
      rows_b       <= 3'd0;
      cols_b       <= 3'd0;
      dim_addr     <= 4'd0;
      select_busy  <= 1'b0;
      select_done  <= 1'b0;
      select_error <= 1'b0;
      err_code     <= ERR_NONE;
      selected_a   <= 4'd0;
      selected_b   <= 4'd0;
    end else begin
      select_error <= 1'b0;

      if (start_select) begin
        op_q        <= op_sel;
        manual_q    <= manual_mode;
        select_done <= 1'b0;
        err_code    <= ERR_NONE;
        phase       <= 1'b0;
        selected_a  <= 4'd0;
        selected_b  <= 4'd0;
        dim_addr    <= 4'd0;
        if (!op_is_valid(op_sel)) begin
          state        <= S_ERR;
          err_code     <= ERR_NO_PAIR;
          select_error <= 1'b1;
          select_busy  <= 1'b0;
        end else if (manual_mode) begin
          state       <= S_WAIT_A;
          select_busy <= 1'b1;
        end else begin
          state       <= S_SCAN_A;
          select_busy <= 1'b1;
        end
      end else begin
        case (state)
          S_WAIT_A: begin
            if (key_confirm) begin
              if (!slot_valid[sw_id]) begin
                state        <= S_ERR;
                err_code     <= ERR_EMPTY;
                select_error <= 1'b1;
                select_busy  <= 1'b0;
              end else begin
                selected_a <= sw_id;
                selected_b <= sw_id;
                dim_addr   <= sw_id;
                phase      <= 1'b0;
                state      <= unary ? S_LOOK_A : S_WAIT_B;
              end
            end
          end

          S_WAIT_B: begin
            if (key_confirm) begin
              if (!slot_valid[sw_id]) begin
                state        <= S_ERR;
                err_code     <= ERR_EMPTY;
                select_error <= 1'b1;
                select_busy  <= 1'b0;
              end else begin
                selected_b <= sw_id;
                dim_addr   <= selected_a;
                phase      <= 1'b0;
                state      <= S_LOOK_A;
              end
            end
          end

          S_LOOK_A: begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              rows_a <= dim_rows;
              cols_a <= dim_cols;
              phase  <= 1'b0;
              if (unary) begin
                state <= S_CHECK;
              end else begin
                dim_addr <= selected_b;
                state    <= S_LOOK_B;
              end
            end
          end

          S_LOOK_B: begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              rows_b <= dim_rows;
              cols_b <= dim_cols;
              phase  <= 1'b0;
              state  <= S_CHECK;
            end
          end

          // dim_addr already equals selected_a on entry, so the valid test
          // cycle doubles as the lookup address cycle.
          S_SCAN_A: begin
            if (!phase) begin
              if (slot_valid[selected_a])
                phase <= 1'b1;
            end else begin
              rows_a <= dim_rows;
              cols_a <= dim_cols;
              phase  <= 1'b0;
              if (unary) begin
                state <= S_CHECK;
              end else begin
                selected_b <= 4'd0;
                dim_addr   <= 4'd0;
                state      <= S_SCAN_B;
              end
            end
          end

          S_SCAN_B: begin
            if (!phase) begin
              if (slot_valid[selected_b])
                phase <= 1'b1;
            end else begin
              rows_b <= dim_rows;
              cols_b <= dim_cols;
              phase  <= 1'b0;
              state  <= S_CHECK;
            end
          end

          S_CHECK: begin
            if (compat_pass) begin
              state       <= S_DONE;
              select_done <= 1'b1;
              select_busy <= 1'b0;
              if (unary)
                selected_b <= selected_a;
            end else if (manual_q) begin
              state        <= S_ERR;
              err_code     <= ERR_DIM;
              select_error <= 1'b1;
              select_busy  <= 1'b0;
            end
          end

          // IDLE, DONE and ERR wait for the next start_select.
          default: begin
          end
        endcase

        if (adv_a) begin
          if (selected_a == 4'd15) begin
            state        <= S_ERR;
            err_code     <= ERR_NO_PAIR;
            select_error <= 1'b1;
            select_busy  <= 1'b0;
          end else begin
            selected_a <= selected_a + 4'd1;
            dim_addr   <= selected_a + 4'd1;
            phase      <= 1'b0;
            state      <= S_SCAN_A;
          end
        end else if (adv_b) begin
          selected_b <= selected_b + 4'd1;
          dim_addr   <= selected_b + 4'd1;
          phase      <= 1'b0;
          state      <= S_SCAN_B;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_selector.sv
// ---------------------------------------------------------------------------
// tb_operand_selector
//   Directed bench for operand_selector. Drivers push the expected outcome
//   ({done, err_code, a, b}) into exp_q; a monitor pops and compares when the
//   DUT raises select_done or pulses select_error. A slot-dimension table
//   answers dim_addr one cycle later.
// ---------------------------------------------------------------------------
module tb_operand_selector;

  logic        clk;
  logic        rst_n;
  logic        start_select;
  logic        manual_mode;
  logic [2:0]  op_sel;
  logic        key_confirm;
  logic [3:0]  sw_id;
  logic [15:0] slot_valid;
  logic [3:0]  dim_addr;
  logic [2:0]  dim_rows;
  logic [2:0]  dim_cols;
  logic        select_busy;
  logic        select_done;
  logic        select_error;
  logic [1:0]  err_code;
  logic [3:0]  selected_a;
  logic [3:0]  selected_b;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  string       name_q[$];

  logic [2:0] rows_tbl [16];
  logic [2:0] cols_tbl [16];

  operand_selector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_select (start_select),
    .manual_mode  (manual_mode),
    .op_sel       (op_sel),
    .key_confirm  (key_confirm),
    .sw_id        (sw_id),
    .slot_valid   (slot_valid),
    .dim_addr     (dim_addr),
    .dim_rows     (dim_rows),
    .dim_cols     (dim_cols),
    .select_busy  (select_busy),
    .select_done  (select_done),
    .select_error (select_error),
    .err_code     (err_code),
    .selected_a   (selected_a),
    .selected_b   (selected_b),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dimension memory model ----------------
  always @(posedge clk) begin
    dim_rows <= rows_tbl[dim_addr];
    dim_cols <= cols_tbl[dim_addr];
  end

  // ---------------- helpers ----------------
  function automatic logic [10:0] res_done(input logic [3:0] a, input logic [3:0] b);
    return {1'b1, 2'b00, a, b};
  endfunction

  function automatic logic [10:0] res_err(input logic [1:0] code);
    return {1'b0, code, 8'h00};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input string name, input logic [10:0] r);
    exp_q.push_back(r);
    name_q.push_back(name);
  endtask

  task automatic clear_slots();
    slot_valid = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      rows_tbl[i] = 3'd0;
      cols_tbl[i] = 3'd0;
    end
  endtask

  task automatic set_slot(input int id, input logic [2:0] r, input logic [2:0] c);
    slot_valid[id] = 1'b1;
    rows_tbl[id]   = r;
    cols_tbl[id]   = c;
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic man, input logic [2:0] op);
    @(negedge clk);
    start_select = 1'b1;
    manual_mode  = man;
    op_sel       = op;
    @(negedge clk);
    start_select = 1'b0;
  endtask

  task automatic do_key(input logic [3:0] id);
    @(negedge clk);
    key_confirm = 1'b1;
    sw_id       = id;
    @(negedge clk);
    key_confirm = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_result(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: no result after %0d cycles, expected %0h", name, budget, exp_q[0]);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;

  always @(negedge clk) begin
    logic [10:0] e;
    logic [10:0] act;
    string       nm;
    if (rst_n) begin
      if (select_error && err_prev) begin
        checks++;
        errors++;
        $display("FAIL error_pulse_width: select_error high 2 cycles, required 1");
      end
      if ((select_done && !done_prev) || select_error) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: done=%0b err=%0b code=%0h a=%0h b=%0h",
                   select_done, select_error, err_code, selected_a, selected_b);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e[10]) act = {select_done, err_code, selected_a, selected_b};
          else       act = {select_done, err_code, 8'h00};
          if (act !== e) begin
            errors++;
            $display("FAIL %s: got done=%0b code=%0h a=%0h b=%0h expected done=%0b code=%0h a=%0h b=%0h",
                     nm, act[10], act[9:8], act[7:4], act[3:0], e[10], e[9:8], e[7:4], e[3:0]);
          end
        end
      end
    end
    done_prev <= select_done;
    err_prev  <= select_error;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    start_select = 1'b0;
    manual_mode  = 1'b0;
    op_sel       = 3'b000;
    key_confirm  = 1'b0;
    sw_id        = 4'd0;
    clear_slots();

    #1;
    check("reset_busy",   {7'd0, select_busy},  8'd0);
    check("reset_done",   {7'd0, select_done},  8'd0);
    check("reset_error",  {7'd0, select_error}, 8'd0);
    check("reset_code",   {6'd0, err_code},     8'd0);
    check("reset_ids",    {selected_a, selected_b}, 8'd0);
    check("reset_addr",   {4'd0, dim_addr},     8'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Manual ADD, slots 2 and 5 both 2x3.
    set_slot(2, 3'd2, 3'd3);
    set_slot(5, 3'd2, 3'd3);
    expect_result("manual_add", res_done(4'd2, 4'd5));
    do_start(1'b1, 3'b001);
    check("busy_after_start", {7'd0, select_busy}, 8'd1);
    do_key(4'd2);
    do_key(4'd5);
    wait_result("manual_add", 20);
    check("busy_in_done", {7'd0, select_busy}, 8'd0);
    // Key press in DONE must be ignored.
    do_key(4'd9);
    idle(3);
    check("done_hold_ids", {selected_a, selected_b}, 8'h25);
    check("done_level", {7'd0, select_done}, 8'd1);

    // Key coincident with start is discarded: picks become 5 then 2.
    expect_result("start_wins_key", res_done(4'd5, 4'd2));
    @(negedge clk);
    start_select = 1'b1; manual_mode = 1'b1; op_sel = 3'b001;
    key_confirm  = 1'b1; sw_id = 4'd2;
    @(negedge clk);
    start_select = 1'b0; key_confirm = 1'b0;
    do_key(4'd5);
    do_key(4'd2);
    wait_result("start_wins_key", 20);

    // Manual MUL: 2x3 * 2x2 mismatch.
    clear_slots();
    set_slot(1, 3'd2, 3'd3);
    set_slot(4, 3'd2, 3'd2);
    expect_result("manual_mul_mismatch", res_err(2'b10));
    do_start(1'b1, 3'b011);
    do_key(4'd1);
    do_key(4'd4);
    wait_result("manual_mul_mismatch", 20);
    idle(5);
    check("err_code_held", {6'd0, err_code}, 8'd2);
    check("busy_in_err", {7'd0, select_busy}, 8'd0);

    // Manual pick of empty slot 7.
    expect_result("manual_empty", res_err(2'b01));
    do_start(1'b1, 3'b011);
    do_key(4'd7);
    wait_result("manual_empty", 10);

    // Manual unary ops.
    clear_slots();
    set_slot(6, 3'd1, 3'd4);
    set_slot(1, 3'd2, 3'd3);
    set_slot(8, 3'd3, 3'd3);
    expect_result("manual_trans", res_done(4'd6, 4'd6));
    do_start(1'b1, 3'b000);
    do_key(4'd6);
    wait_result("manual_trans", 20);
    expect_result("manual_det_nonsquare", res_err(2'b10));
    do_start(1'b1, 3'b100);
    do_key(4'd1);
    wait_result("manual_det_nonsquare", 20);
    expect_result("manual_det_square", res_done(4'd8, 4'd8));
    do_start(1'b1, 3'b100);
    do_key(4'd8);
    wait_result("manual_det_square", 20);

    // Auto MUL: 3 (2x3) and 9 (3x4); 3*3 fails, 3*9 passes.
    clear_slots();
    set_slot(3, 3'd2, 3'd3);
    set_slot(9, 3'd3, 3'd4);
    expect_result("auto_mul", res_done(4'd3, 4'd9));
    do_start(1'b0, 3'b011);
    wait_result("auto_mul", 100);

    // Auto MUL with nothing stored: scan exhausts.
    clear_slots();
    expect_result("auto_empty", res_err(2'b11));
    do_start(1'b0, 3'b011);
    wait_result("auto_empty", 60);
    idle(3);
    check("auto_empty_code_held", {6'd0, err_code}, 8'd3);

    // Auto DET: slot 0 2x3 rejected, slot 1 3x3 accepted.
    set_slot(0, 3'd2, 3'd3);
    set_slot(1, 3'd3, 3'd3);
    expect_result("auto_det", res_done(4'd1, 4'd1));
    do_start(1'b0, 3'b100);
    wait_result("auto_det", 40);

    // Unassigned op encodings go straight to ERR.
    for (int op = 5; op < 8; op++) begin
      logic [2:0] opv;
      opv = 3'(op);
      expect_result("invalid_op", res_err(2'b11));
      do_start(1'b1, opv);
      wait_result("invalid_op", 3);
    end

    // Restart mid-scan: the aborted MUL scan must report nothing.
    clear_slots();
    do_start(1'b0, 3'b011);
    idle(5);
    set_slot(10, 3'd2, 3'd2);
    expect_result("restart_trans", res_done(4'd10, 4'd10));
    do_start(1'b0, 3'b000);
    wait_result("restart_trans", 60);
    idle(30);

    // Reset during LOOK_A: all outputs 0, no pulse afterwards.
    set_slot(2, 3'd2, 3'd3);
    set_slot(5, 3'd2, 3'd3);
    do_start(1'b1, 3'b001);
    do_key(4'd2);
    do_key(4'd5);
    rst_n = 1'b0;
    #1;
    check("midreset_busy",  {7'd0, select_busy},  8'd0);
    check("midreset_done",  {7'd0, select_done},  8'd0);
    check("midreset_error", {7'd0, select_error}, 8'd0);
    check("midreset_code",  {6'd0, err_code},     8'd0);
    check("midreset_ids",   {selected_a, selected_b}, 8'd0);
    check("midreset_addr",  {4'd0, dim_addr},     8'd0);
    idle(2);
    rst_n = 1'b1;
    idle(20);

    // Recovery after reset: auto SCALAR picks the first valid slot.
    expect_result("post_reset_scalar", res_done(4'd2, 4'd2));
    do_start(1'b0, 3'b010);
    wait_result("post_reset_scalar", 30);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
